down_count_monitor: RTL and testbench

- Downstream consumer of the mod-16 synchronous down counter.
- Samples the counter's 4-bit output {Qd,Qc,Qb,Qa} on an enable strobe and checks that each sample is exactly the previous sample minus 1, modulo 16.
- Produces a lock status, an error flag and error count, a terminal-count (0) pulse, a wrap (0→15) pulse and a wrap counter.
- Used as an on-board self-checker and period divider behind the counter.

---
 rtl/down_count_pkg.sv | 18 +
 rtl/down_step_check.sv | 17 +
 rtl/down_count_monitor.sv | 132 +++++++++++++
 tb/tb_down_count_monitor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/down_count_pkg.sv
// Shared definitions for the down-counter monitor: state encoding, counter width
// and the modulo decrement used by the step check.
package down_count_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    SYNCING = 2'd1,
    LOCKED  = 2'd2
  } mon_state_e;

  // Expected successor of a down counter; 0 wraps to all-ones.
  function automatic logic [CNT_W-1:0] dec_mod(input logic [CNT_W-1:0] v);
    return v - CNT_W'(1);
  endfunction

endpackage

// File: rtl/down_step_check.sv
// Combinational step classifier for a down-counter sample against its predecessor.
module down_step_check
  import down_count_pkg::*;
(
  input  logic [CNT_W-1:0] prev_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             good_step_c,
  output logic             is_zero_c,
  output logic             is_wrap_c
);

  assign good_step_c = (cnt_i == dec_mod(prev_i));
  assign is_zero_c   = (cnt_i == '0);
  // A wrap is the single good step that crosses from 0 to all-ones.
  assign is_wrap_c   = (prev_i == '0) && (cnt_i == '1);

endmodule

// File: rtl/down_count_monitor.sv
// Lock/error/wrap monitor for a mod-16 down counter sampled on an enable strobe.
module down_count_monitor
  import down_count_pkg::*;
#(
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned WRAP_W   = 8,
  parameter int unsigned ERR_W    = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [CNT_W-1:0]  cnt_in,
  output logic              locked,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              tc_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int unsigned RUN_W = 4;

  mon_state_e        state_q, state_d;
  logic [CNT_W-1:0]  prev_q, prev_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              tc_q, tc_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic              good_step_c;
  logic              is_zero_c;
  logic              is_wrap_c;
  logic [RUN_W-1:0]  run_inc_c;

  down_step_check u_step_check (
    .prev_i      (prev_q),
    .cnt_i       (cnt_in),
    .good_step_c (good_step_c),
    .is_zero_c   (is_zero_c),
    .is_wrap_c   (is_wrap_c)
  );

  assign run_inc_c = run_q + RUN_W'(1);

  // Next-state, counters and pulse generation; only accepted samples move state.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    tc_d       = 1'b0;
    wrap_d     = 1'b0;

    if (en) begin
      prev_d = cnt_in;

      if (state_q != UNSYNC) begin
        tc_d = is_zero_c;
        if (is_wrap_c) begin
          wrap_d     = 1'b1;
          wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
        end
      end

      case (state_q)
        UNSYNC: begin
          state_d = SYNCING;
          run_d   = '0;
        end
        SYNCING: begin
          if (good_step_c) begin
            run_d = run_inc_c;
            if (run_inc_c == RUN_W'(LOCK_LEN)) state_d = LOCKED;
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (!good_step_c) begin
            err_d   = 1'b1;
            state_d = SYNCING;
            run_d   = '0;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
        default: begin
          state_d = UNSYNC;
          run_d   = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= UNSYNC;
      prev_q     <= '0;
      run_q      <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      tc_q       <= 1'b0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      tc_q       <= tc_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign tc_pulse   = tc_q;
  assign wrap_pulse = wrap_q;
  assign wrap_cnt   = wrap_cnt_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Self-checking bench for down_count_monitor: directed scenarios plus random traffic vs a reference model.
module tb_down_count_monitor;

  localparam int unsigned LOCK_LEN = 4;
  localparam int unsigned WRAP_W   = 8;
  localparam int unsigned ERR_W    = 4;
  localparam int          ERR_MAX  = (1 << ERR_W) - 1;
  localparam int          WRAP_MOD = 1 << WRAP_W;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              en  = 1'b0;
  logic [3:0]        cnt_in = 4'd0;
  logic              locked;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;
  logic              tc_pulse;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_cnt;

  down_count_monitor #(
    .LOCK_LEN (LOCK_LEN),
    .WRAP_W   (WRAP_W),
    .ERR_W    (ERR_W)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .cnt_in     (cnt_in),
    .locked     (locked),
    .err        (err),
    .err_cnt    (err_cnt),
    .tc_pulse   (tc_pulse),
    .wrap_pulse (wrap_pulse),
    .wrap_cnt   (wrap_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history-level view of the sampled sequence.
  bit m_have_prev;
  int m_prev;
  int m_streak;
  bit m_locked;
  bit m_err;
  int m_errs;
  int m_wraps;
  bit m_tc;
  bit m_wrap;
  int cur;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have_prev = 0; m_prev = 0; m_streak = 0; m_locked = 0;
    m_err = 0; m_errs = 0; m_wraps = 0; m_tc = 0; m_wrap = 0;
  endtask

  task automatic model_update(input bit c_clr, input bit c_en, input int c);
    bit good;
    m_tc   = 0;
    m_wrap = 0;
    if (c_clr) begin
      model_reset();
    end else if (c_en) begin
      if (!m_have_prev) begin
        m_have_prev = 1;
        m_streak    = 0;
      end else begin
        good = (c == (m_prev + 15) % 16);
        if (c == 0) m_tc = 1;
        if (good && m_prev == 0 && c == 15) begin
          m_wrap  = 1;
          m_wraps = (m_wraps + 1) % WRAP_MOD;
        end
        if (m_locked) begin
          if (!good) begin
            m_err    = 1;
            m_errs   = (m_errs + 1 > ERR_MAX) ? ERR_MAX : m_errs + 1;
            m_locked = 0;
            m_streak = 0;
          end
        end else if (good) begin
          m_streak++;
          if (m_streak >= LOCK_LEN) m_locked = 1;
        end else begin
          m_streak = 0;
        end
      end
      m_prev = c;
    end
  endtask

  task automatic compare_all();
    check("locked",     int'(locked),     int'(m_locked));
    check("err",        int'(err),        int'(m_err));
    check("err_cnt",    int'(err_cnt),    m_errs);
    check("tc_pulse",   int'(tc_pulse),   int'(m_tc));
    check("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
    check("wrap_cnt",   int'(wrap_cnt),   m_wraps);
  endtask

  // One clock: apply inputs, advance the model on the edge, compare just after it.
  task automatic step(input bit c_clr, input bit c_en, input int c);
    clr    = c_clr;
    en     = c_en;
    cnt_in = 4'(c);
    @(posedge clk);
    model_update(c_clr, c_en, c);
    #1;
    compare_all();
    if (c_en && !c_clr) cur = c;
  endtask

  task automatic sample(input int c);
    step(1'b0, 1'b1, c);
  endtask

  task automatic good_steps(input int n);
    for (int i = 0; i < n; i++) sample((cur + 15) % 16);
  endtask

  initial begin
    model_reset();
    cur = 0;

    // Reset state.
    step(1'b1, 1'b0, 0);
    check("reset_locked", int'(locked), 0);
    check("reset_wrap_cnt", int'(wrap_cnt), 0);

    // Lock-up from 15 down to 11.
    sample(15); sample(14); sample(13); sample(12);
    check("pre_lock", int'(locked), 0);
    sample(11);
    check("lockup_locked", int'(locked), 1);
    check("lockup_err", int'(err), 0);

    // Terminal count and wrap while locked.
    good_steps(11);
    check("tc_seen", int'(tc_pulse), 1);
    sample(15);
    check("wrap_seen", int'(wrap_pulse), 1);
    check("wrap_cnt_one", int'(wrap_cnt), 1);
    sample(14);
    check("wrap_ends", int'(wrap_pulse), 0);
    check("still_locked", int'(locked), 1);

    // Mismatch while locked, then relock with err kept sticky.
    sample(13); sample(11);
    check("mis_err", int'(err), 1);
    check("mis_err_cnt", int'(err_cnt), 1);
    check("mis_unlocked", int'(locked), 0);
    good_steps(4);
    check("relocked", int'(locked), 1);
    check("err_sticky", int'(err), 1);

    // Enable gap holds state.
    sample((cur + 15) % 16);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3);
    sample((cur + 15) % 16);
    check("gap_locked", int'(locked), 1);

    // Error counter saturation across relock cycles.
    for (int i = 0; i < 20; i++) begin
      sample((cur + 3) % 16);
      good_steps(LOCK_LEN + 1);
    end
    check("err_saturated", int'(err_cnt), ERR_MAX);

    // A full wrap-counter rollover.
    for (int i = 0; i < WRAP_MOD; i++) good_steps(16);

    // clr beats a pending wrap step.
    while (cur != 0) good_steps(1);
    check("pre_clr_locked", int'(locked), 1);
    step(1'b1, 1'b1, 15);
    check("clr_locked", int'(locked), 0);
    check("clr_wrap_pulse", int'(wrap_pulse), 0);
    check("clr_wrap_cnt", int'(wrap_cnt), 0);
    check("clr_err_cnt", int'(err_cnt), 0);
    sample(14);
    check("clr_unsync_no_tc", int'(tc_pulse), 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r_clr;
      bit r_en;
      int c;
      r_clr = ($urandom_range(0, 99) == 0);
      r_en  = ($urandom_range(0, 3) != 0);
      c     = ($urandom_range(0, 9) < 8) ? (cur + 15) % 16 : int'($urandom_range(0, 15));
      step(r_clr, r_en, c);
      if (r_clr) cur = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
